// File: rtl/desloc_pkg.sv
// Shared constants for the iterative shifter: op codes, FSM states, default sizes.
// WIDTH_DEF must equal 2**AMT_W_DEF so every amount from the selector is in range.
package desloc_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AMT_W_DEF = 5;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL};
  endfunction

  // LOAD and every shift seed the data register from entrada; NOP/reserved leave it alone.
  function automatic logic writes_data(input logic [2:0] op);
    return (op == OP_LOAD) || is_shift(op);
  endfunction

endpackage

// File: rtl/desloc_passo.sv
// Combinational shift/rotate step: applies op by amt bits to a data word.
// Zero latency; purely combinational, no flow control.
module desloc_passo
  import desloc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  output logic [WIDTH-1:0] o_data
);

  logic [2*WIDTH-1:0] w_dup;
  logic [WIDTH-1:0]   w_ror;
  logic [WIDTH-1:0]   w_rol;

  // Rotations read a window out of the word concatenated with itself.
  assign w_dup = {i_data, i_data};
  assign w_ror = WIDTH'(w_dup >> i_amt);
  assign w_rol = WIDTH'(w_dup >> (WIDTH - int'(i_amt)));

  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_SLL:                   o_data = i_data << i_amt;
      OP_SRL:                   o_data = i_data >> i_amt;
      OP_SRA:                   o_data = $signed(i_data) >>> i_amt;
      OP_ROR:                   o_data = w_ror;
      OP_ROL:                   o_data = w_rol;
      OP_NOP, OP_LOAD, OP_RSVD: o_data = i_data;
      default:                  o_data = i_data;
    endcase
  end

endmodule

// File: rtl/desloc_sequencial.sv
// Iterative EX-stage shifter: start -> SHIFT (1 bit/cycle, n+1 edges) -> DONE pulse -> IDLE.
// SHIFT_FAST_EN applies the whole amount in one SHIFT edge; start is ignored unless IDLE.
module desloc_sequencial
  import desloc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] n,
  input  logic [WIDTH-1:0] entrada,
  output logic [WIDTH-1:0] saida,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_count;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] w_amt;
  logic [WIDTH-1:0] w_step;

`ifdef SHIFT_FAST_EN
  // r_count only holds the latched amount here; the barrel does it all in one edge.
  assign w_amt = r_count;
`else
  assign w_amt = AMT_W'(1);
`endif

  desloc_passo #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_passo (
    .i_op   (r_op),
    .i_data (r_data),
    .i_amt  (w_amt),
    .o_data (w_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = is_shift(op) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
`ifdef SHIFT_FAST_EN
        w_next = ST_DONE;
`else
        if (r_count == '0) w_next = ST_DONE;
`endif
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_SHIFT);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= OP_NOP;
      r_count <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_count <= n;
            if (writes_data(op)) r_data <= entrada;
          end
        end
        ST_SHIFT: begin
`ifdef SHIFT_FAST_EN
          r_data <= w_step;
`else
          if (r_count != '0) begin
            r_data  <= w_step;
            r_count <= r_count - AMT_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign saida = r_data;

endmodule
